// File: rtl/rv_csr_access_ctrl.sv
// CSR access sequencer: arbitrates trap-unit writes and pipeline CSR ops into READ/WRITE/RESP transactions.
// Optional stall counter output o_stall_cnt is built when RV_CSR_ACCESS_STATS_EN is defined.
module rv_csr_access_ctrl #(
    parameter int IDX_W = 12,
    parameter int XLEN  = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [IDX_W-1:0] i_req_idx,
    input  logic [1:0]       i_req_op,
    input  logic             i_req_sel,
    input  logic [4:0]       i_req_imm,
    input  logic [XLEN-1:0]  i_req_data,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [XLEN-1:0]  o_rsp_data,
    output logic             o_rsp_illegal,
    input  logic             i_trap_valid,
    input  logic [IDX_W-1:0] i_trap_idx,
    input  logic [XLEN-1:0]  i_trap_data,
    output logic             o_trap_done,
    output logic [IDX_W-1:0] o_csr_idx,
    output logic             o_csr_re,
    input  logic [XLEN-1:0]  i_csr_rdata,
    output logic             o_csr_we,
    output logic [XLEN-1:0]  o_csr_wdata,
    output logic [1:0]       o_dbg_state
`ifdef RV_CSR_ACCESS_STATS_EN
    ,
    output logic [31:0]      o_stall_cnt
`endif
);
    // Handshakes: a request transfers on a rising edge where valid && ready are both high;
    // o_rsp_valid/data/illegal hold steady until i_rsp_ready (or i_flush) is seen.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   src_q;
    logic [XLEN-1:0]   old_q;
    logic              trap_q;
    logic              illegal_q;
    logic              rsp_valid_q;
    logic              rsp_illegal_q;
    logic [XLEN-1:0]   rsp_data_q;
    logic              trap_done_q;
    logic              csr_re_q;
    logic              csr_we_q;
    logic [XLEN-1:0]   csr_wdata_q;

    logic [XLEN-1:0]   wdata_d;
    logic              suppress_d;
    logic              read_only_d;

    // New value is formed from the live read data so it can be registered on the READ->WRITE edge.
    always_comb begin
        wdata_d = i_csr_rdata;
        case (op_q)
            2'b01:   wdata_d = src_q;
            2'b10:   wdata_d = i_csr_rdata | src_q;
            2'b11:   wdata_d = i_csr_rdata & ~src_q;
            default: wdata_d = i_csr_rdata;
        endcase
    end

    assign suppress_d  = (op_q == 2'b00) || (op_q[1] && (src_q == '0));
    assign read_only_d = (idx_q[IDX_W-1 -: 2] == 2'b11);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            op_q          <= 2'b00;
            src_q         <= '0;
            old_q         <= '0;
            trap_q        <= 1'b0;
            illegal_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_illegal_q <= 1'b0;
            rsp_data_q    <= '0;
            trap_done_q   <= 1'b0;
            csr_re_q      <= 1'b0;
            csr_we_q      <= 1'b0;
            csr_wdata_q   <= '0;
        end else begin
            trap_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_trap_valid) begin
                        idx_q       <= i_trap_idx;
                        trap_q      <= 1'b1;
                        csr_we_q    <= 1'b1;
                        csr_wdata_q <= i_trap_data;
                        trap_done_q <= 1'b1;
                        state_q     <= WRITE;
                    end else if (i_req_valid && !i_flush) begin
                        idx_q    <= i_req_idx;
                        op_q     <= i_req_op;
                        src_q    <= i_req_sel ? {{(XLEN-5){1'b0}}, i_req_imm} : i_req_data;
                        trap_q   <= 1'b0;
                        csr_re_q <= 1'b1;
                        state_q  <= READ;
                    end
                end
                READ: begin
                    csr_re_q <= 1'b0;
                    if (i_flush) begin
                        state_q <= IDLE;
                    end else begin
                        old_q     <= i_csr_rdata;
                        illegal_q <= !suppress_d && read_only_d;
                        if (!suppress_d && !read_only_d) begin
                            csr_we_q    <= 1'b1;
                            csr_wdata_q <= wdata_d;
                        end
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    // The write is the commit point: a flush here only drops the response.
                    csr_we_q <= 1'b0;
                    if (trap_q || i_flush) begin
                        state_q <= IDLE;
                    end else begin
                        rsp_valid_q   <= 1'b1;
                        rsp_data_q    <= old_q;
                        rsp_illegal_q <= illegal_q;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (i_flush || i_rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_illegal_q <= 1'b0;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready drops combinationally when a trap preempts so a same-cycle pipeline request is not lost.
    assign o_req_ready   = (state_q == IDLE) && !i_trap_valid;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_data    = rsp_data_q;
    assign o_rsp_illegal = rsp_illegal_q;
    assign o_trap_done   = trap_done_q;
    assign o_csr_idx     = idx_q;
    assign o_csr_re      = csr_re_q;
    assign o_csr_we      = csr_we_q;
    assign o_csr_wdata   = csr_wdata_q;
    assign o_dbg_state   = state_q;

`ifdef RV_CSR_ACCESS_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
        end else if (i_req_valid && !o_req_ready) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rv_csr_access_ctrl.sv
// Self-checking bench for rv_csr_access_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_rv_csr_access_ctrl;
  logic        i_clk;
  logic        i_reset;
  logic        i_flush;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [11:0] i_req_idx;
  logic [1:0]  i_req_op;
  logic        i_req_sel;
  logic [4:0]  i_req_imm;
  logic [31:0] i_req_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_illegal;
  logic        i_trap_valid;
  logic [11:0] i_trap_idx;
  logic [31:0] i_trap_data;
  logic        o_trap_done;
  logic [11:0] o_csr_idx;
  logic        o_csr_re;
  logic [31:0] i_csr_rdata;
  logic        o_csr_we;
  logic [31:0] o_csr_wdata;
  logic [1:0]  o_dbg_state;
`ifdef RV_CSR_ACCESS_STATS_EN
  logic [31:0] o_stall_cnt;
`endif

  rv_csr_access_ctrl #(.IDX_W(12), .XLEN(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_idx(i_req_idx),
    .i_req_op(i_req_op), .i_req_sel(i_req_sel), .i_req_imm(i_req_imm), .i_req_data(i_req_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_illegal(o_rsp_illegal), .i_trap_valid(i_trap_valid), .i_trap_idx(i_trap_idx),
    .i_trap_data(i_trap_data), .o_trap_done(o_trap_done), .o_csr_idx(o_csr_idx),
    .o_csr_re(o_csr_re), .i_csr_rdata(i_csr_rdata), .o_csr_we(o_csr_we),
    .o_csr_wdata(o_csr_wdata), .o_dbg_state(o_dbg_state)
`ifdef RV_CSR_ACCESS_STATS_EN
    , .o_stall_cnt(o_stall_cnt)
`endif
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // CSR file seen by the DUT, written only through o_csr_we
  logic [31:0] env_mem [0:4095];
  assign i_csr_rdata = env_mem[o_csr_idx];
  always @(posedge i_clk) if (o_csr_we) env_mem[o_csr_idx] <= o_csr_wdata;

  logic [11:0] pool [8] = '{12'h340, 12'h341, 12'h342, 12'h343, 12'h300, 12'hC00, 12'hC01, 12'hC80};

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: one transaction record plus cycles elapsed since it was accepted
  logic [31:0] m_mem [0:4095];
  bit          m_busy = 1'b0;
  bit          m_trap;
  int          m_cyc;
  logic [11:0] m_idx;
  logic [31:0] m_old, m_new;
  bit          m_write, m_illegal;
  bit          took_req, took_trap;
  logic [31:0] m_stall = 0;

  always @(posedge i_clk) begin
    logic [31:0] src;
    bit quiet, ro;
    took_req  = 1'b0;
    took_trap = 1'b0;
    if (i_reset) m_stall = 0;
    else if (i_req_valid && (m_busy || i_trap_valid)) m_stall = m_stall + 1;
    if (i_reset) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (i_trap_valid) begin
        m_busy = 1'b1; m_trap = 1'b1; m_cyc = 1;
        m_idx = i_trap_idx; m_new = i_trap_data; m_write = 1'b1; m_illegal = 1'b0;
        took_trap = 1'b1;
      end else if (i_req_valid && !i_flush) begin
        src = i_req_sel ? 32'(i_req_imm) : i_req_data;
        m_old = m_mem[i_req_idx];
        if (i_req_op == 2'b01) m_new = src;
        else if (i_req_op == 2'b10) m_new = m_old | src;
        else m_new = m_old & ~src;
        quiet = (i_req_op == 2'b00) || (i_req_op != 2'b01 && src == 0);
        ro = (i_req_idx >= 12'hC00);
        m_write = !quiet && !ro;
        m_illegal = !quiet && ro;
        m_busy = 1'b1; m_trap = 1'b0; m_cyc = 1; m_idx = i_req_idx;
        took_req = 1'b1;
      end
    end else if (m_trap) begin
      m_mem[m_idx] = m_new;
      m_busy = 1'b0;
    end else begin
      if (m_cyc == 1) begin
        if (i_flush) m_busy = 1'b0; else m_cyc = 2;
      end else if (m_cyc == 2) begin
        if (m_write) m_mem[m_idx] = m_new;
        if (i_flush) m_busy = 1'b0; else m_cyc = 3;
      end else if (i_flush || i_rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge i_clk) begin
    bit e_re, e_we, e_rsp, e_done;
    if (chk_en) begin
      e_re   = m_busy && !m_trap && m_cyc == 1;
      e_done = m_busy && m_trap;
      e_we   = e_done || (m_busy && !m_trap && m_cyc == 2 && m_write);
      e_rsp  = m_busy && !m_trap && m_cyc == 3;
      cmp("m_ready", o_req_ready, !m_busy && !i_trap_valid);
      cmp("m_re", o_csr_re, e_re);
      cmp("m_we", o_csr_we, e_we);
      cmp("m_done", o_trap_done, e_done);
      cmp("m_rsp_valid", o_rsp_valid, e_rsp);
      if (e_re || e_we) cmp("m_idx", o_csr_idx, m_idx);
      if (e_we) cmp("m_wdata", o_csr_wdata, m_new);
      if (e_rsp) begin
        cmp("m_rsp_data", o_rsp_data, m_old);
        cmp("m_rsp_illegal", o_rsp_illegal, m_illegal);
      end
`ifdef RV_CSR_ACCESS_STATS_EN
      cmp("m_stall", o_stall_cnt, m_stall);
`endif
    end
  end

  // driver tasks
  task automatic send(input logic [11:0] idx, input logic [1:0] op, input logic sel,
                      input logic [4:0] imm, input logic [31:0] data);
    i_req_idx = idx; i_req_op = op; i_req_sel = sel; i_req_imm = imm; i_req_data = data;
    i_req_valid = 1'b1;
  endtask

  task automatic drive_random();
    if (took_req) i_req_valid = 1'b0;
    if (took_trap) i_trap_valid = 1'b0;
    if (!i_req_valid && $urandom_range(0, 2) == 0)
      send(pool[$urandom_range(0, 7)], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
    if (!i_trap_valid && $urandom_range(0, 7) == 0) begin
      i_trap_idx = pool[$urandom_range(0, 7)];
      i_trap_data = $urandom;
      i_trap_valid = 1'b1;
    end
    i_flush = ($urandom_range(0, 9) == 0);
    i_rsp_ready = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [31:0] stall0;
    for (int i = 0; i < 4096; i++) begin
      env_mem[i] = $urandom;
      m_mem[i] = env_mem[i];
    end
    env_mem[12'h340] = 32'h0000_00F0; m_mem[12'h340] = 32'h0000_00F0;
    env_mem[12'hC00] = 32'h1234_5678; m_mem[12'hC00] = 32'h1234_5678;
    env_mem[12'h343] = 32'h0000_1111; m_mem[12'h343] = 32'h0000_1111;
    env_mem[12'h300] = 32'h0000_1800; m_mem[12'h300] = 32'h0000_1800;
    i_reset = 1'b1; i_flush = 1'b0; i_req_valid = 1'b0; i_req_idx = '0; i_req_op = '0;
    i_req_sel = 1'b0; i_req_imm = '0; i_req_data = '0; i_rsp_ready = 1'b1;
    i_trap_valid = 1'b0; i_trap_idx = '0; i_trap_data = '0;
    repeat (3) @(negedge i_clk);
    cmp("rst_ready", o_req_ready, 1);
    cmp("rst_rsp_valid", o_rsp_valid, 0);
    cmp("rst_illegal", o_rsp_illegal, 0);
    cmp("rst_done", o_trap_done, 0);
    cmp("rst_re", o_csr_re, 0);
    cmp("rst_we", o_csr_we, 0);
    cmp("rst_rsp_data", o_rsp_data, 0);
    cmp("rst_idx", o_csr_idx, 0);
    cmp("rst_wdata", o_csr_wdata, 0);
    #1 i_reset = 1'b0; chk_en = 1'b1;

    // RS 0x340 (0xF0) with 0x0F
    @(negedge i_clk); #1 send(12'h340, 2'b10, 1'b0, 5'd0, 32'h0000_000F);
    @(negedge i_clk); cmp("t1_re", o_csr_re, 1); cmp("t1_idx", o_csr_idx, 12'h340); #1 i_req_valid = 1'b0;
    @(negedge i_clk); cmp("t1_we", o_csr_we, 1); cmp("t1_wdata", o_csr_wdata, 32'h0000_00FF);
    @(negedge i_clk); cmp("t1_rsp", o_rsp_valid, 1); cmp("t1_data", o_rsp_data, 32'h0000_00F0);
    cmp("t1_illegal", o_rsp_illegal, 0);
    @(negedge i_clk); cmp("t1_ready", o_req_ready, 1);

    // RC uimm=0: suppressed write
    #1 send(12'h340, 2'b11, 1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge i_clk); #1 i_req_valid = 1'b0;
    @(negedge i_clk); cmp("t2_we", o_csr_we, 0);
    @(negedge i_clk); cmp("t2_rsp", o_rsp_valid, 1); cmp("t2_data", o_rsp_data, 32'h0000_00FF);
    cmp("t2_illegal", o_rsp_illegal, 0);

    // RW to read-only cycle CSR
    @(negedge i_clk); #1 send(12'hC00, 2'b01, 1'b0, 5'd0, 32'h5);
    @(negedge i_clk); #1 i_req_valid = 1'b0;
    @(negedge i_clk); cmp("t3_we", o_csr_we, 0);
    @(negedge i_clk); cmp("t3_rsp", o_rsp_valid, 1); cmp("t3_illegal", o_rsp_illegal, 1);
    cmp("t3_data", o_rsp_data, 32'h1234_5678);

    // trap and pipeline request in the same cycle
    @(negedge i_clk);
    #1 i_trap_idx = 12'h341; i_trap_data = 32'h8000_0004; i_trap_valid = 1'b1;
    send(12'h342, 2'b01, 1'b0, 5'd0, 32'h7);
    #1 cmp("t4_ready_preempt", o_req_ready, 0);
    @(negedge i_clk); cmp("t4_done", o_trap_done, 1); cmp("t4_we", o_csr_we, 1);
    cmp("t4_idx", o_csr_idx, 12'h341); cmp("t4_wdata", o_csr_wdata, 32'h8000_0004);
    #1 i_trap_valid = 1'b0;
    @(negedge i_clk); cmp("t4_ready_idle", o_req_ready, 1); cmp("t4_done_pulse", o_trap_done, 0);
    @(negedge i_clk); cmp("t4_re", o_csr_re, 1); cmp("t4_re_idx", o_csr_idx, 12'h342); #1 i_req_valid = 1'b0;
    repeat (3) @(negedge i_clk);

    // flush during READ
    #1 send(12'h343, 2'b01, 1'b0, 5'd0, 32'h55);
    @(negedge i_clk); cmp("t5a_re", o_csr_re, 1); #1 i_req_valid = 1'b0; i_flush = 1'b1;
    @(negedge i_clk); cmp("t5a_we", o_csr_we, 0); cmp("t5a_rsp", o_rsp_valid, 0);
    cmp("t5a_ready", o_req_ready, 1); cmp("t5a_mem", env_mem[12'h343], 32'h0000_1111);
    // flush during WRITE
    #1 i_flush = 1'b0; send(12'h343, 2'b01, 1'b0, 5'd0, 32'hA5);
    @(negedge i_clk); #1 i_req_valid = 1'b0;
    @(negedge i_clk); cmp("t5b_we", o_csr_we, 1); cmp("t5b_wdata", o_csr_wdata, 32'hA5); #1 i_flush = 1'b1;
    @(negedge i_clk); cmp("t5b_rsp", o_rsp_valid, 0); cmp("t5b_ready", o_req_ready, 1);
    cmp("t5b_mem", env_mem[12'h343], 32'hA5);

    // response held for four cycles while a new request waits
    #1 i_flush = 1'b0; i_rsp_ready = 1'b0; send(12'h300, 2'b10, 1'b0, 5'd0, 32'h8);
    @(negedge i_clk); #1 i_req_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
`ifdef RV_CSR_ACCESS_STATS_EN
    stall0 = o_stall_cnt;
`else
    stall0 = 0;
`endif
    #1 send(12'h340, 2'b00, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cmp("t6_rsp", o_rsp_valid, 1); cmp("t6_data", o_rsp_data, 32'h0000_1800);
      cmp("t6_ready", o_req_ready, 0);
      @(negedge i_clk);
    end
`ifdef RV_CSR_ACCESS_STATS_EN
    cmp("t6_stall", o_stall_cnt, stall0 + 32'd4);
`endif
    #1 i_rsp_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk); cmp("t6_next_re", o_csr_re, 1); cmp("t6_mem", env_mem[12'h300], 32'h0000_1808);
    #1 i_req_valid = 1'b0;
    repeat (3) @(negedge i_clk);

    // reset in the middle of a transaction
    #1 send(12'h342, 2'b01, 1'b0, 5'd0, 32'hDEAD);
    @(negedge i_clk); cmp("t7_re", o_csr_re, 1); #1 i_req_valid = 1'b0; i_reset = 1'b1;
    @(negedge i_clk); cmp("t7_re_after", o_csr_re, 0); cmp("t7_we", o_csr_we, 0);
    cmp("t7_ready", o_req_ready, 1); #1 i_reset = 1'b0;
    @(negedge i_clk); cmp("t7_mem", env_mem[12'h342], 32'h7);

    // randomized traffic
    repeat (3000) begin
      @(negedge i_clk);
      #1 drive_random();
    end
    #1 i_req_valid = 1'b0; i_trap_valid = 1'b0; i_flush = 1'b0; i_rsp_ready = 1'b1;
    repeat (10) @(negedge i_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv_csr_access_ctrl.md
Name: rv_csr_access_ctrl

Overview:
Sequences every access to the CSR file (counters plus machine CSRs) as a 3-stage read-modify-write transaction. Arbitrates between two requesters: the execute stage (CSRRW/CSRRS/CSRRC and immediate forms) and the trap unit (direct writes to mepc/mcause/mtval). Sits between the pipeline/trap logic and the CSR register file. Enforces RISC-V write-suppression and read-only rules.

Parameters:
IDX_W, 12, CSR address width
XLEN, 32, CSR data width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous reset, active-high
i_flush  in  1  pipeline flush; kills an in-flight pipeline transaction
i_req_valid  in  1  pipeline CSR request
o_req_ready  out  1  controller can accept a request (IDLE only)
i_req_idx  in  IDX_W  CSR address
i_req_op  in  2  00 none, 01 RW, 10 RS, 11 RC
i_req_sel  in  1  1 = source is zero-extended i_req_imm, 0 = i_req_data
i_req_imm  in  5  uimm field
i_req_data  in  XLEN  rs1 value
o_rsp_valid  out  1  response to pipeline
i_rsp_ready  in  1  pipeline accepts response
o_rsp_data  out  XLEN  old CSR value (rd result)
o_rsp_illegal  out  1  illegal-access flag, valid with o_rsp_valid
i_trap_valid  in  1  trap-unit write request, write-only, plain write
i_trap_idx  in  IDX_W  trap CSR address
i_trap_data  in  XLEN  trap write data
o_trap_done  out  1  one-cycle pulse when trap write performed
o_csr_idx  out  IDX_W  address to CSR file
o_csr_re  out  1  read strobe
i_csr_rdata  in  XLEN  CSR file combinational read data for o_csr_idx
o_csr_we  out  1  write strobe
o_csr_wdata  out  XLEN  write data

Behaviour:
- Clock i_clk; reset is synchronous and active-high (i_reset), sampled on rising i_clk.
- Reset: state IDLE; o_req_ready=1 in IDLE; o_rsp_valid, o_rsp_illegal, o_trap_done, o_csr_re, o_csr_we = 0; o_rsp_data, o_csr_idx, o_csr_wdata = 0. Reset mid-transaction aborts with no write.
- States: IDLE, READ, WRITE, RESP.
- IDLE: o_req_ready=1. i_trap_valid has priority: latch trap idx/data, go WRITE (no read). Otherwise i_req_valid && !i_flush: latch idx/op/sel/source (imm zero-extended to XLEN), go READ. Both asserted: trap taken, pipeline request stays pending (ready drops).
- READ: o_csr_idx=latched idx, o_csr_re=1; capture i_csr_rdata into old-value register; go WRITE.
- WRITE: new value RW: src; RS: old|src; RC: old&~src. o_csr_we=1 unless suppressed. Suppression: RS/RC with src==0 (rs1=x0 / uimm=0), or op==00. Illegal: write not suppressed and idx[11:10]==2'b11 (read-only) -> no write, o_rsp_illegal=1. Trap transactions always write (no read-only check), pulse o_trap_done, return to IDLE. Pipeline transactions go RESP.
- RESP: o_rsp_valid=1 holding o_rsp_data=old value, illegal flag; leave to IDLE on i_rsp_ready.
- Latency: pipeline accept at cycle N -> o_csr_re at N+1, o_csr_we at N+2, o_rsp_valid at N+3. Trap accept at N -> write and o_trap_done at N+1.
- Flush: in READ -> abort, no write, no response, IDLE next cycle. In WRITE -> write still committed (commit point), response dropped, IDLE next. In RESP -> o_rsp_valid deasserts, IDLE next. Flush never affects trap transactions.
- o_csr_re/o_csr_we never asserted simultaneously; at most one CSR write per transaction.
- i_trap_valid arriving while busy is held by the requester until taken in IDLE.

Optional Feature:
RV_CSR_ACCESS_STATS_EN: adds output o_stall_cnt (32 bits), counting cycles with i_req_valid=1 and o_req_ready=0 (incl. trap preemption); clears on reset, wraps at 2^32. Without macro: port absent, no counter logic.

Test Plan:
- CSR 0x340 holds 0x0000_00F0; RS, sel=0, data 0x0F -> re at N+1, we at N+2 wdata 0x0000_00FF, rsp_data 0x0000_00F0 at N+3, illegal=0.
- RC, sel=1, imm=0 on 0x340 -> no o_csr_we, rsp_data = current value, illegal=0.
- RW to 0xC00 (cycle, read-only) data 0x5 -> no write, o_rsp_illegal=1, rsp_data=current cycle value.
- i_trap_valid (idx 0x341, data 0x8000_0004) and i_req_valid same cycle -> trap write next cycle with o_trap_done pulse; pipeline request accepted the following IDLE cycle.
- i_flush in READ -> no write, no o_rsp_valid, o_req_ready=1 next cycle; i_flush in WRITE -> write occurs, no response.
- Hold i_rsp_ready=0 for 4 cycles in RESP -> o_rsp_valid/data stable, o_req_ready=0; with STATS_EN, a new request held during those cycles increments o_stall_cnt by 4.
